// File: rtl/column_scan_arbiter_pkg.sv
// Shared types and helpers for the column scan arbiter.
// Optional grant timeout is enabled by the COL_ARB_GRANT_TIMEOUT_EN macro.
package lib_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      GNT  = 2'd2
   } col_arb_state_e;

   localparam int COL_ARB_MAX_COLS    = 64;
   localparam int COL_ARB_TIMEOUT_DEF = 15;
   localparam int COL_ARB_TO_W        = $clog2(COL_ARB_TIMEOUT_DEF + 1);

   // OR of the indices of all set bits; exact for a one-hot input.
   function automatic int unsigned onehot_to_index(
      input logic [COL_ARB_MAX_COLS-1:0] oh
   );
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < COL_ARB_MAX_COLS; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/column_scan_arbiter_prio_enc.sv
// Lowest-index one-hot select of a request vector.
// Ports: req_i (WIDTH requests), sel_o (one-hot, 0 when no request).
module col_prio_enc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [WIDTH-1:0] sel_o
);

   // Two's-complement trick isolates the lowest set bit.
   assign sel_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/column_scan_arbiter.sv
// Round-robin column arbiter: one pass grants each masked request once, low index first.
// Ports: clk_i, reset_i, enable_i, refresh_i, req_i, ack_i -> gnt_o, yadd_o, gnt_valid_o,
// grp_release_o, busy_o, timeout_o. Macro COL_ARB_GRANT_TIMEOUT_EN adds the grant timeout.
module column_scan_arbiter
   import lib_arbiter_pkg::*;
#(
   parameter int LVL_COLS       = 8,
   parameter int LVL_COL_ADD    = $clog2(LVL_COLS),
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   refresh_i,
   input  logic [LVL_COLS-1:0]    req_i,
   input  logic                   ack_i,
   output logic [LVL_COLS-1:0]    gnt_o,
   output logic [LVL_COL_ADD-1:0] yadd_o,
   output logic                   gnt_valid_o,
   output logic                   grp_release_o,
   output logic                   busy_o,
   output logic                   timeout_o
);

   col_arb_state_e state_q, state_d;

   logic [LVL_COLS-1:0]    mask_q, mask_d;
   logic [LVL_COLS-1:0]    gnt_q, gnt_d;
   logic [LVL_COL_ADD-1:0] yadd_q, yadd_d;
   logic                   valid_q, valid_d;
   logic                   rel_q, rel_d;
   logic                   to_d;
   logic                   expire;

   logic [LVL_COLS-1:0]         mask_req;
   logic [LVL_COLS-1:0]         sel;
   logic [COL_ARB_MAX_COLS-1:0] sel_w;
   logic [LVL_COLS-1:0]         above_gnt;

   assign mask_req  = req_i & mask_q;
   assign sel_w     = COL_ARB_MAX_COLS'(sel);
   // Keeps only bits above the current grant; granting the top bit empties it.
   assign above_gnt = ~((gnt_q << 1) - LVL_COLS'(1));

   col_prio_enc #(
      .WIDTH (LVL_COLS)
   ) u_prio (
      .req_i (mask_req),
      .sel_o (sel)
   );

`ifdef COL_ARB_GRANT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            to_q;

   assign expire = (state_q == GNT) &&
                   (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   // Restarts on every entry to GNT; never passes the expiry value.
   assign cnt_d  = ((state_q == GNT) && (state_d == GNT)) ?
                   cnt_q + TO_W'(1) : '0;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout_o = to_q;
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         mask_q  <= '1;
         gnt_q   <= '0;
         yadd_q  <= '0;
         valid_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         gnt_q   <= gnt_d;
         yadd_q  <= yadd_d;
         valid_q <= valid_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (refresh_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (enable_i) state_d = ARB;
            ARB: begin
               if (enable_i) state_d = (|mask_req) ? GNT : IDLE;
            end
            GNT: if (ack_i || expire) state_d = ARB;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      mask_d  = mask_q;
      gnt_d   = gnt_q;
      yadd_d  = yadd_q;
      valid_d = valid_q;
      rel_d   = 1'b0;
      to_d    = 1'b0;
      if (refresh_i) begin
         mask_d  = '1;
         gnt_d   = '0;
         yadd_d  = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ARB: begin
               if (enable_i) begin
                  if (|mask_req) begin
                     gnt_d   = sel;
                     yadd_d  = LVL_COL_ADD'(onehot_to_index(sel_w));
                     valid_d = 1'b1;
                  end else begin
                     rel_d  = 1'b1;
                     mask_d = '1;
                  end
               end
            end
            GNT: begin
               if (ack_i || expire) begin
                  mask_d  = above_gnt;
                  gnt_d   = '0;
                  yadd_d  = '0;
                  valid_d = 1'b0;
                  to_d    = !ack_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt_o         = gnt_q;
   assign yadd_o        = yadd_q;
   assign gnt_valid_o   = valid_q;
   assign grp_release_o = rel_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_column_scan_arbiter.sv
// Directed scoreboard bench for column_scan_arbiter (LVL_COLS=8, TIMEOUT_CYCLES=4).
// Expected grants are queued as stimulus is applied and compared as grants appear.
module tb_column_scan_arbiter;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       enable_i;
   logic       refresh_i;
   logic [7:0] req_i;
   logic       ack_i;
   logic [7:0] gnt_o;
   logic [2:0] yadd_o;
   logic       gnt_valid_o;
   logic       grp_release_o;
   logic       busy_o;
   logic       timeout_o;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] yadd;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   column_scan_arbiter #(
      .LVL_COLS       (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .enable_i      (enable_i),
      .refresh_i     (refresh_i),
      .req_i         (req_i),
      .ack_i         (ack_i),
      .gnt_o         (gnt_o),
      .yadd_o        (yadd_o),
      .gnt_valid_o   (gnt_valid_o),
      .grp_release_o (grp_release_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] g, input logic [2:0] y);
      exp_t e;
      e.gnt  = g;
      e.yadd = y;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input string tag, output int lat);
      exp_t e;
      lat = 0;
      while (!gnt_valid_o && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_valid"}, 32'(gnt_valid_o), 32'h1);
      check({tag, "_queued"}, 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_gnt"}, 32'(gnt_o), 32'(e.gnt));
         check({tag, "_yadd"}, 32'(yadd_o), 32'(e.yadd));
      end
   endtask

   task automatic do_ack();
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check("ack_clear", 32'(gnt_valid_o), 32'h0);
   endtask

   task automatic do_refresh();
      enable_i  = 1'b0;
      refresh_i = 1'b1;
      tick();
      refresh_i = 1'b0;
   endtask

   initial begin
      int lat;
      reset_i   = 1'b1;
      enable_i  = 1'b0;
      refresh_i = 1'b0;
      req_i     = 8'h00;
      ack_i     = 1'b0;
      tick();
      tick();
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_valid", 32'(gnt_valid_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_rel", 32'(grp_release_o), 32'h0);
      check("rst_to", 32'(timeout_o), 32'h0);
      #2 reset_i = 1'b0;
      tick();

      // pass over 0xA4
      req_i    = 8'hA4;
      push(8'h04, 3'd2);
      push(8'h20, 3'd5);
      push(8'h80, 3'd7);
      enable_i = 1'b1;
      wait_grant("t1_g0", lat);
      check("t1_lat_en", 32'(lat), 32'd2);
      do_ack();
      wait_grant("t1_g1", lat);
      check("t1_lat_ack", 32'(lat), 32'd1);
      do_ack();
      wait_grant("t1_g2", lat);
      do_ack();
      check("t1_norel", 32'(grp_release_o), 32'h0);
      tick();
      check("t1_rel", 32'(grp_release_o), 32'h1);
      check("t1_busy", 32'(busy_o), 32'h0);
      enable_i = 1'b0;
      tick();
      check("t1_rel_end", 32'(grp_release_o), 32'h0);

      // empty pass
      req_i    = 8'h00;
      enable_i = 1'b1;
      tick();
      check("t2_valid0", 32'(gnt_valid_o), 32'h0);
      check("t2_rel0", 32'(grp_release_o), 32'h0);
      tick();
      check("t2_rel", 32'(grp_release_o), 32'h1);
      check("t2_valid1", 32'(gnt_valid_o), 32'h0);
      enable_i = 1'b0;
      tick();
      check("t2_rel_end", 32'(grp_release_o), 32'h0);
      check("t2_busy", 32'(busy_o), 32'h0);

      // grant held after request withdrawal
      req_i    = 8'h20;
      push(8'h20, 3'd5);
      enable_i = 1'b1;
      wait_grant("t3_g", lat);
      req_i    = 8'h00;
      enable_i = 1'b0;
      repeat (5) tick();
      check("t3_hold", 32'(gnt_o), 32'h20);
      check("t3_hold_v", 32'(gnt_valid_o), 32'h1);
      enable_i = 1'b1;
      do_ack();
      tick();
      check("t3_rel", 32'(grp_release_o), 32'h1);
      enable_i = 1'b0;
      tick();

      // refresh wins over ack
      req_i    = 8'h04;
      push(8'h04, 3'd2);
      enable_i = 1'b1;
      wait_grant("t4_g", lat);
      req_i     = 8'h05;
      refresh_i = 1'b1;
      ack_i     = 1'b1;
      tick();
      refresh_i = 1'b0;
      ack_i     = 1'b0;
      enable_i  = 1'b0;
      check("t4_gnt", 32'(gnt_o), 32'h0);
      check("t4_yadd", 32'(yadd_o), 32'h0);
      check("t4_valid", 32'(gnt_valid_o), 32'h0);
      check("t4_busy", 32'(busy_o), 32'h0);
      check("t4_rel", 32'(grp_release_o), 32'h0);
      tick();
      check("t4_rel2", 32'(grp_release_o), 32'h0);
      push(8'h01, 3'd0);
      enable_i = 1'b1;
      wait_grant("t4_g2", lat);
      do_refresh();

      // async reset in GNT
      req_i    = 8'hFF;
      push(8'h01, 3'd0);
      enable_i = 1'b1;
      wait_grant("t5_g", lat);
      #2 reset_i = 1'b1;
      #1;
      check("t5_gnt", 32'(gnt_o), 32'h0);
      check("t5_valid", 32'(gnt_valid_o), 32'h0);
      check("t5_busy", 32'(busy_o), 32'h0);
      #3 reset_i = 1'b0;
      push(8'h01, 3'd0);
      wait_grant("t5_g2", lat);
      check("t5_lat", 32'(lat), 32'd2);
      do_refresh();

      // grant timeout
      req_i    = 8'h03;
      push(8'h01, 3'd0);
      enable_i = 1'b1;
      wait_grant("t6_g", lat);
`ifdef COL_ARB_GRANT_TIMEOUT_EN
      repeat (3) tick();
      check("t6_pre_to", 32'(timeout_o), 32'h0);
      check("t6_pre_gnt", 32'(gnt_o), 32'h01);
      tick();
      check("t6_to", 32'(timeout_o), 32'h1);
      check("t6_to_valid", 32'(gnt_valid_o), 32'h0);
      push(8'h02, 3'd1);
      wait_grant("t6_g2", lat);
      check("t6_to_end", 32'(timeout_o), 32'h0);
      do_ack();
      tick();
      check("t6_rel", 32'(grp_release_o), 32'h1);
`else
      for (int i = 0; i < 50; i++) begin
         tick();
         check("t6_hold", 32'(gnt_o), 32'h01);
         check("t6_no_to", 32'(timeout_o), 32'h0);
      end
`endif
      do_refresh();

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
